cmos_rgb565_capture: RTL

Camera-side capture stage for the OV5640 path. It samples the sensor's 8-bit DVP bus on the sensor pixel clock and packs byte pairs into RGB565 pixels. It suppresses the first frames after reset while the sensor settles, and tracks line and pixel position. It also flags malformed frames. Its pixel stream feeds the frame-buffer writer that decouples the camera domain from the 74.25 MHz HDMI timing chain.

---
 rtl/cmos_rgb565_capture_if.sv | 28 ++
 rtl/cmos_rgb565_capture.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/cmos_rgb565_capture_if.sv
// Sensor DVP input bus and packed RGB565 pixel stream of the OV5640 capture stage.
// O_pix_valid is a one-cycle strobe with no ready: the consumer must accept every strobe, at most one per two I_pclk cycles.
interface cmos_rgb565_capture_if;
  logic        I_vsync;
  logic        I_href;
  logic [7:0]  I_data;
  logic        O_pix_valid;
  logic [15:0] O_pix_data;
  logic        O_sof;
  logic        O_eol;
  logic [11:0] O_x;
  logic [11:0] O_y;
  logic        O_frame_done;
  logic        O_frame_err;
  logic [7:0]  O_frame_cnt;

  modport master (
    input  I_vsync, I_href, I_data,
    output O_pix_valid, O_pix_data, O_sof, O_eol, O_x, O_y,
    output O_frame_done, O_frame_err, O_frame_cnt
  );

  modport slave (
    output I_vsync, I_href, I_data,
    input  O_pix_valid, O_pix_data, O_sof, O_eol, O_x, O_y,
    input  O_frame_done, O_frame_err, O_frame_cnt
  );
endinterface

// File: rtl/cmos_rgb565_capture.sv
// Packs OV5640 DVP byte pairs into RGB565 pixels, skips settling frames after reset,
// tracks x/y position and flags malformed frames.
module cmos_rgb565_capture #(
  parameter int H_RES      = 1280,
  parameter int V_RES      = 720,
  parameter int FRAME_SKIP = 10
) (
  input  logic                         I_pclk,
  input  logic                         I_rst,
  cmos_rgb565_capture_if.master        cam,
  output logic [1:0]                   dbg_state
);

  typedef enum logic [1:0] {ST_SKIP = 2'd0, ST_WAIT = 2'd1, ST_ACTIVE = 2'd2} state_t;

  localparam state_t      ST_RESET  = (FRAME_SKIP == 0) ? ST_WAIT : ST_SKIP;
  localparam logic [7:0]  SKIP_LAST = (FRAME_SKIP == 0) ? 8'd0 : 8'(FRAME_SKIP - 1);
  localparam logic [11:0] X_LAST    = 12'(H_RES - 1);
  localparam logic [11:0] X_FULL    = 12'(H_RES);
  localparam logic [11:0] Y_FULL    = 12'(V_RES);
  localparam logic [11:0] CNT_MAX   = 12'hFFF;

  logic        vs_s1, href_s1, vs_d, href_d;
  logic [7:0]  data_s1, hi_byte, skip_cnt, frame_cnt;
  logic [11:0] x_cnt, y_cnt, p_x, p_y;
  logic [15:0] p_data;
  logic        phase, line_seen, err_acc;
  logic        p_valid, p_sof, p_eol, p_done, p_err;
  state_t      state;

  logic vs_rise, href_fall, line_err, frame_err_now, emit;

  assign vs_rise       = vs_s1 & ~vs_d;
  assign href_fall     = href_d & ~href_s1;
  assign line_err      = href_fall & ((x_cnt != X_FULL) | phase);
  assign frame_err_now = vs_rise & ((y_cnt != Y_FULL) | href_s1);
  assign emit          = href_s1 & phase & (state == ST_ACTIVE) & ~vs_rise;
  assign dbg_state     = state;

  always_ff @(posedge I_pclk or posedge I_rst) begin
    if (I_rst) begin
      vs_s1   <= 1'b0;
      href_s1 <= 1'b0;
      data_s1 <= 8'd0;
      vs_d    <= 1'b0;
      href_d  <= 1'b0;
    end else begin
      vs_s1   <= cam.I_vsync;
      href_s1 <= cam.I_href;
      data_s1 <= cam.I_data;
      vs_d    <= vs_s1;
      href_d  <= href_s1;
    end
  end

  always_ff @(posedge I_pclk or posedge I_rst) begin
    if (I_rst) begin
      state     <= ST_RESET;
      skip_cnt  <= 8'd0;
      frame_cnt <= 8'd0;
      x_cnt     <= 12'd0;
      y_cnt     <= 12'd0;
      phase     <= 1'b0;
      line_seen <= 1'b0;
      err_acc   <= 1'b0;
      hi_byte   <= 8'd0;
      p_valid   <= 1'b0;
      p_data    <= 16'd0;
      p_sof     <= 1'b0;
      p_eol     <= 1'b0;
      p_x       <= 12'd0;
      p_y       <= 12'd0;
      p_done    <= 1'b0;
      p_err     <= 1'b0;
    end else begin
      p_valid <= 1'b0;
      p_sof   <= 1'b0;
      p_eol   <= 1'b0;
      p_done  <= 1'b0;
      p_err   <= 1'b0;

      // A vsync rise drops any half-collected pixel, so the phase restarts.
      phase <= (href_s1 && !vs_rise) ? ~phase : 1'b0;
      if (href_s1 && !phase) hi_byte <= data_s1;

      if (emit) begin
        p_valid <= 1'b1;
        p_data  <= {hi_byte, data_s1};
        p_x     <= x_cnt;
        p_y     <= y_cnt;
        p_sof   <= (x_cnt == 12'd0) && (y_cnt == 12'd0);
        p_eol   <= (x_cnt == X_LAST);
        x_cnt   <= (x_cnt != CNT_MAX) ? x_cnt + 12'd1 : x_cnt;
      end

      if (vs_rise) begin
        x_cnt     <= 12'd0;
        y_cnt     <= 12'd0;
        line_seen <= 1'b0;
        err_acc   <= 1'b0;
        case (state)
          ST_SKIP: begin
            if (skip_cnt == SKIP_LAST) state <= ST_WAIT;
            else                       skip_cnt <= skip_cnt + 8'd1;
          end
          ST_WAIT: state <= ST_ACTIVE;
          default: begin
            p_done    <= 1'b1;
            p_err     <= err_acc | line_err | frame_err_now;
            frame_cnt <= frame_cnt + 8'd1;
          end
        endcase
      end else begin
        err_acc <= err_acc | line_err;
        if (href_fall) begin
          x_cnt     <= 12'd0;
          line_seen <= 1'b0;
          if (line_seen && y_cnt != CNT_MAX) y_cnt <= y_cnt + 12'd1;
        end else if (href_s1) begin
          line_seen <= 1'b1;
        end
      end
    end
  end

  // Final output register: gives the two-cycle latency from the s1 sample to the outputs.
  always_ff @(posedge I_pclk or posedge I_rst) begin
    if (I_rst) begin
      cam.O_pix_valid  <= 1'b0;
      cam.O_pix_data   <= 16'd0;
      cam.O_sof        <= 1'b0;
      cam.O_eol        <= 1'b0;
      cam.O_x          <= 12'd0;
      cam.O_y          <= 12'd0;
      cam.O_frame_done <= 1'b0;
      cam.O_frame_err  <= 1'b0;
      cam.O_frame_cnt  <= 8'd0;
    end else begin
      cam.O_pix_valid  <= p_valid;
      cam.O_pix_data   <= p_data;
      cam.O_sof        <= p_sof;
      cam.O_eol        <= p_eol;
      cam.O_x          <= p_x;
      cam.O_y          <= p_y;
      cam.O_frame_done <= p_done;
      cam.O_frame_err  <= p_err;
      cam.O_frame_cnt  <= frame_cnt;
    end
  end

endmodule
